// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: byte FIFO plus launch sequencer feeding a UART transmitter
// Ports: clk/rst (sync, active-high); i_s_data/i_s_valid/o_s_ready byte stream in;
//   i_flush discards queued bytes; o_tx_data/o_tx_start launch a byte, i_tx_busy/i_tx_done
//   report transmitter progress; o_fifo_count/o_fifo_empty/o_fifo_full show queue state;
//   i_cts_n (active-low clear-to-send) exists only when UART_TX_CTS_EN is defined.
module uart_tx_fifo_feeder #(
  parameter int DEPTH = 64,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic             i_flush,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_busy,
  input  logic             i_tx_done,
`ifdef UART_TX_CTS_EN
  input  logic             i_cts_n,
`endif
  output logic [CNT_W-1:0] o_fifo_count,
  output logic             o_fifo_empty,
  output logic             o_fifo_full
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT_DONE} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_tx_data;
  logic             r_tx_start;
  logic             w_push, w_pop, w_cts_ok;
`ifdef UART_TX_CTS_EN
  // cts_n is asynchronous; reset to "not clear" so nothing launches until it is seen low
  logic r_cts_meta, r_cts_sync;
  always_ff @(posedge clk)
    if (rst) {r_cts_meta, r_cts_sync} <= 2'b11;
    else {r_cts_meta, r_cts_sync} <= {i_cts_n, r_cts_meta};
  assign w_cts_ok = !r_cts_sync;
`else
  assign w_cts_ok = 1'b1;
`endif
  assign o_fifo_count = r_count;
  assign o_fifo_empty = r_count == '0;
  assign o_fifo_full  = r_count == CNT_W'(DEPTH);
  assign o_s_ready    = !o_fifo_full;
  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = r_tx_start;
  // a push coinciding with flush is dropped
  assign w_push = i_s_valid && o_s_ready && !i_flush;
  always_comb begin
    w_pop  = r_state == IDLE && !o_fifo_empty && !i_tx_busy && w_cts_ok;
    w_next = r_state == IDLE ? (w_pop ? WAIT_DONE : IDLE) : (i_tx_done ? IDLE : WAIT_DONE);
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_s_data;
  // flush realigns rd_ptr to wr_ptr; a same-cycle pop has already captured its byte
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= i_flush ? r_wr_ptr : r_rd_ptr + AW'(w_pop);
      r_count  <= i_flush ? '0 : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
endmodule
